// File: rtl/gpio_apb_sched_if.sv
// Requester command/response bundle plus APB master port of the GPIO scheduler.
// master: the scheduler's view; slave: requesters and APB slave together.
interface gpio_apb_sched_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [3*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic               psel;
    logic               penable;
    logic [31:0]        paddr;
    logic               pwrite;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;

    modport master (
        input  req_valid, req_op, req_wdata,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, paddr, pwrite, pwdata
    );

    modport slave (
        output req_valid, req_op, req_wdata,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, paddr, pwrite, pwdata
    );
endinterface

// File: rtl/gpio_apb_sched.sv
// Round-robin scheduler sharing one GRGPIO APB slave among NREQ requesters.
// Optional ACCESS-phase timeout abort: define GPIO_SCHED_TIMEOUT_EN.
module gpio_apb_sched #(
    parameter int          NREQ = 4,
    parameter logic [31:0] BASE = 32'h0
`ifdef GPIO_SCHED_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 255
`endif
) (
    input logic              clk,
    input logic              rst,
    gpio_apb_sched_if.master bus
);

    localparam int PW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_gnt;
    logic              r_psel;
    logic              r_penable;
    logic [31:0]       r_paddr;
    logic              r_pwrite;
    logic [31:0]       r_pwdata;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_any;
    logic [PW-1:0]     w_gnt;
    logic [PW-1:0]     w_next_ptr;
    logic [NREQ-1:0]   w_gnt_oh;
    logic [2:0]        w_op;
    logic [31:0]       w_wd;
    logic [31:0]       w_off;
    logic              w_wr;
    logic [31:0]       w_pwd;

`ifdef GPIO_SCHED_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int TW = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
    logic [TW-1:0]     r_cnt;
`endif

    // Pick the first valid requester at or above the round-robin pointer.
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_any && bus.req_valid[idx]) begin
                w_any = 1'b1;
                w_gnt = PW'(idx);
            end
        end
    end

    assign w_next_ptr = (w_gnt == PW'(NREQ - 1)) ? '0 : w_gnt + PW'(1);
    assign w_gnt_oh   = (r_state == IDLE && w_any) ? (ONE << w_gnt) : '0;
    assign w_op       = bus.req_op[3*int'(w_gnt) +: 3];
    assign w_wd       = bus.req_wdata[32*int'(w_gnt) +: 32];

    // Map opcode onto the GPIO register or its OR/AND/XOR alias.
    always_comb begin
        w_off = 32'h0;
        w_wr  = 1'b0;
        w_pwd = 32'h0;
        unique case (w_op)
            3'd0: begin w_off = 32'h00; w_wr = 1'b0; w_pwd = 32'h0;  end
            3'd1: begin w_off = 32'h04; w_wr = 1'b1; w_pwd = w_wd;   end
            3'd2: begin w_off = 32'h54; w_wr = 1'b1; w_pwd = w_wd;   end
            3'd3: begin w_off = 32'h64; w_wr = 1'b1; w_pwd = ~w_wd;  end
            3'd4: begin w_off = 32'h74; w_wr = 1'b1; w_pwd = w_wd;   end
            3'd5: begin w_off = 32'h08; w_wr = 1'b1; w_pwd = w_wd;   end
            3'd6: begin w_off = 32'h58; w_wr = 1'b1; w_pwd = w_wd;   end
            3'd7: begin w_off = 32'h68; w_wr = 1'b1; w_pwd = ~w_wd;  end
        endcase
    end

    // Transfer FSM; every APB and response output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef GPIO_SCHED_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_rsp_valid <= '0;
                    if (w_any) begin
                        r_gnt     <= w_gnt;
                        r_ptr     <= w_next_ptr;
                        r_paddr   <= BASE + w_off;
                        r_pwrite  <= w_wr;
                        r_pwdata  <= w_pwd;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
`ifdef GPIO_SCHED_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= ONE << r_gnt;
                        r_rsp_rdata <= r_pwrite ? 32'h0 : bus.prdata;
                        r_rsp_err   <= bus.pslverr;
                        r_state     <= RESP;
                    end
`ifdef GPIO_SCHED_TIMEOUT_EN
                    else if (r_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= ONE << r_gnt;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
`endif
                end
                RESP: begin
                    r_rsp_valid <= '0;
                    r_rsp_rdata <= 32'h0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_gnt_oh;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.paddr     = r_paddr;
    assign bus.pwrite    = r_pwrite;
    assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_gpio_apb_sched.sv
// Scoreboard bench for gpio_apb_sched with a behavioural GRGPIO APB slave.
// Timeout scenario is compiled in when GPIO_SCHED_TIMEOUT_EN is defined.
module tb_gpio_apb_sched;

    localparam int          NREQ = 4;
    localparam logic [31:0] BASE = 32'h8000_0100;
`ifdef GPIO_SCHED_TIMEOUT_EN
    localparam int          TO = 16;
`else
    localparam int          TO = 32'h7fff_ffff;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_apb_sched_if #(.NREQ(NREQ)) bus ();

`ifdef GPIO_SCHED_TIMEOUT_EN
    gpio_apb_sched #(.NREQ(NREQ), .BASE(BASE), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`else
    gpio_apb_sched #(.NREQ(NREQ), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    typedef struct {
        int          g;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          pen;
        int          t0;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int pen_cnt = 0;
    int exp_ptr = 0;
    int wait_n = 0;
    int acc_cnt;
    logic err_n = 1'b0;
    logic [31:0] ext_pins = 32'h0;
    logic [31:0] g_out, g_dir;
    logic [31:0] m_out = 32'h0;
    logic [31:0] m_dir = 32'h0;
    logic [31:0] s_off;
    logic [31:0] pins;
    logic [2:0]  t_op[NREQ];
    logic [31:0] t_wd[NREQ];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural GRGPIO slave
    assign s_off      = bus.paddr - BASE;
    assign pins       = (g_out & g_dir) | (ext_pins & ~g_dir);
    assign bus.pready = (acc_cnt >= wait_n);
    assign bus.pslverr = err_n && bus.pready && bus.psel && bus.penable;
    assign bus.prdata = (s_off == 32'h00) ? pins :
                        (s_off == 32'h04) ? g_out :
                        (s_off == 32'h08) ? g_dir : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= 0;
            g_out   <= 32'h0;
            g_dir   <= 32'h0;
        end else if (bus.psel && bus.penable) begin
            if (bus.pready) begin
                acc_cnt <= 0;
                if (bus.pwrite && !err_n) begin
                    case (s_off)
                        32'h04: g_out <= bus.pwdata;
                        32'h54: g_out <= g_out | bus.pwdata;
                        32'h64: g_out <= g_out & bus.pwdata;
                        32'h74: g_out <= g_out ^ bus.pwdata;
                        32'h08: g_dir <= bus.pwdata;
                        32'h58: g_dir <= g_dir | bus.pwdata;
                        32'h68: g_dir <= g_dir & bus.pwdata;
                        default: ;
                    endcase
                end
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: APB setup contents and responses against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            pen_cnt = 0;
        end else begin
            if (bus.psel && bus.penable) pen_cnt++;
            if (bus.psel && !bus.penable && q.size() > 0) begin
                chk("paddr", bus.paddr, q[0].addr);
                chk("pwrite", 32'(bus.pwrite), 32'(q[0].wr));
                chk("pwdata", bus.pwdata, q[0].wd);
            end
            if (bus.rsp_valid != '0) begin
                if (q.size() == 0) begin
                    chk("rsp_unexp", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << e.g));
                    chk("rsp_rdata", bus.rsp_rdata, e.rd);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_lat", 32'(cyc - e.t0), 32'(e.lat));
                    chk("pen_cyc", 32'(pen_cnt), 32'(e.pen));
                    pen_cnt = 0;
                end
            end
        end
    end

    function automatic int rr_pick(input logic [NREQ-1:0] pend);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic push_exp(input int g, input logic [2:0] op,
                            input logic [31:0] wd);
        exp_t x;
        logic [31:0] off, pw;
        logic wr;
        off = 32'h0; pw = 32'h0; wr = 1'b1;
        case (op)
            3'd0: begin off = 32'h00; wr = 1'b0; end
            3'd1: begin off = 32'h04; pw = wd;  end
            3'd2: begin off = 32'h54; pw = wd;  end
            3'd3: begin off = 32'h64; pw = ~wd; end
            3'd4: begin off = 32'h74; pw = wd;  end
            3'd5: begin off = 32'h08; pw = wd;  end
            3'd6: begin off = 32'h58; pw = wd;  end
            default: begin off = 32'h68; pw = ~wd; end
        endcase
        x.g = g; x.addr = BASE + off; x.wr = wr; x.wd = pw; x.t0 = cyc;
        if (wait_n >= TO) begin
            x.err = 1'b1; x.rd = 32'h0; x.lat = 2 + TO; x.pen = TO;
        end else begin
            x.err = err_n;
            x.rd  = wr ? 32'h0 : ((m_out & m_dir) | (ext_pins & ~m_dir));
            x.lat = 3 + wait_n;
            x.pen = wait_n + 1;
            if (!err_n) begin
                case (op)
                    3'd1: m_out = wd;
                    3'd2: m_out = m_out | wd;
                    3'd3: m_out = m_out & ~wd;
                    3'd4: m_out = m_out ^ wd;
                    3'd5: m_dir = wd;
                    3'd6: m_dir = m_dir | wd;
                    3'd7: m_dir = m_dir & ~wd;
                    default: ;
                endcase
            end
        end
        q.push_back(x);
    endtask

    task automatic run_reqs(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        int g, last;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op[3*i +: 3]    = t_op[i];
            bus.req_wdata[32*i +: 32] = t_wd[i];
        end
        pend = mask;
        bus.req_valid = pend;
        last = -1;
        for (int n = 0; n < 300 && pend != '0; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                g = rr_pick(pend);
                chk("grant", 32'(bus.req_ready), 32'(1 << g));
                if (last >= 0) chk("spacing", 32'(cyc - last), 32'(4 + wait_n));
                last = cyc;
                push_exp(g, t_op[g], t_wd[g]);
                exp_ptr = (g + 1) % NREQ;
                @(posedge clk); #1;
                pend[g] = 1'b0;
                bus.req_valid = pend;
            end
        end
        if (pend != '0) chk("grant_to", 32'(pend), 32'h0);
        bus.req_valid = '0;
        for (int n = 0; n < 500 && q.size() > 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_to", 32'(q.size()), 32'h0);
            q.delete();
        end
    endtask

    task automatic single(input int g, input logic [2:0] op,
                          input logic [31:0] wd);
        t_op[g] = op;
        t_wd[g] = wd;
        run_reqs(NREQ'(1) << g);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_valid = '0;
        m_out = 32'h0; m_dir = 32'h0; exp_ptr = 0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_op[i] = 3'd0;
            t_wd[i] = 32'h0;
        end
        do_reset();
        @(negedge clk);
        chk("rst_psel", 32'(bus.psel), 32'h0);
        chk("rst_penable", 32'(bus.penable), 32'h0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);

        // Single requester: dir, out, readback
        single(0, 3'd5, 32'hFF);
        single(0, 3'd1, 32'hA5);
        single(0, 3'd0, 32'h0);

        // Four simultaneous set-out requests, round robin from 0
        do_reset();
        single(3, 3'd5, 32'hFF);
        for (int i = 0; i < NREQ; i++) begin
            t_op[i] = 3'd2;
            t_wd[i] = 32'h1 << i;
        end
        run_reqs(4'hF);
        single(0, 3'd0, 32'h0);

        // Clear / toggle through alias registers
        single(1, 3'd1, 32'hFF);
        single(2, 3'd3, 32'h0F);
        single(0, 3'd0, 32'h0);
        single(3, 3'd4, 32'hFF);
        single(0, 3'd0, 32'h0);

        // External pins with direction input
        do_reset();
        ext_pins = 32'h3C;
        single(1, 3'd0, 32'h0);
        single(2, 3'd1, 32'h55);
        single(1, 3'd0, 32'h0);

        // Wait states and slave error
        wait_n = 5; err_n = 1'b1;
        single(0, 3'd1, 32'h77);
        wait_n = 0; err_n = 1'b0;
        single(0, 3'd6, 32'hF0);
        single(0, 3'd0, 32'h0);

        // Reset during ACCESS
        wait_n = 20;
        @(posedge clk); #1;
        bus.req_op[3*2 +: 3] = 3'd1;
        bus.req_wdata[32*2 +: 32] = 32'h99;
        bus.req_valid = 4'b0100;
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                seen = bus.penable;
            end
            chk("access_seen", 32'(seen), 32'h1);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        bus.req_valid = '0;
        #1;
        chk("rst_async_psel", 32'(bus.psel), 32'h0);
        chk("rst_async_pen", 32'(bus.penable), 32'h0);
        m_out = 32'h0; m_dir = 32'h0; exp_ptr = 0;
        q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_n = 0;
        repeat (5) @(negedge clk);
        t_op[0] = 3'd0; t_wd[0] = 32'h0;
        t_op[3] = 3'd0; t_wd[3] = 32'h0;
        run_reqs(4'b1001);

`ifdef GPIO_SCHED_TIMEOUT_EN
        // Slave never ready: abort after TIMEOUT_CYC access cycles
        wait_n = 1000;
        single(1, 3'd1, 32'h12);
        wait_n = 0;
        single(0, 3'd0, 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/gpio_apb_sched.md
Name: gpio_apb_sched

Overview:
- Round-robin scheduler that shares one GRGPIO APB slave port between NREQ on-chip requesters.
- Each requester issues pin-level commands: read pins, write/set/clear/toggle output, write/set/clear direction.
- The block serialises the commands into single APB transfers. It uses the GPIO's OR/AND/XOR alias registers, so set/clear/toggle are atomic and need no read-modify-write.
- Sits between the requesters (CPU-side peripherals, DMA, debug) and the grgpio APB slave select.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BASE, 32'h0, APB base address of the GPIO instance.
- TIMEOUT_CYC, 255, ACCESS-phase cycles before abort (only with GPIO_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  command valid per requester
- req_ready  out  NREQ  command accepted (one-cycle pulse on grant)
- req_op  in  3*NREQ  opcode per requester, requester i at bits [3i+2:3i]
- req_wdata  in  32*NREQ  data/mask per requester
- rsp_valid  out  NREQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  32  read data, valid with rsp_valid
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid
- psel  out  1  APB select
- penable  out  1  APB enable
- paddr  out  32  APB address
- pwrite  out  1  APB write
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready  in  1  APB ready (tie 1 for grgpio)
- pslverr  in  1  APB error

Behaviour:
- Reset values (asynchronous): all outputs 0; FSM in IDLE; round-robin pointer 0. Reset mid-transfer drops psel/penable immediately; the lost command gets no response.
- Opcode map: op, register offset, pwrite, pwdata.
  - 0: read pins, 0x00, 0, 0.
  - 1: write out, 0x04, 1, wdata.
  - 2: set out, 0x54 (OR), 1, wdata.
  - 3: clear out, 0x64 (AND), 1, ~wdata.
  - 4: toggle out, 0x74 (XOR), 1, wdata.
  - 5: write dir, 0x08, 1, wdata.
  - 6: set dir, 0x58, 1, wdata.
  - 7: clear dir, 0x68, 1, ~wdata.
- paddr = BASE + offset, 32-bit, wrap ignored.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the pointer upward, modulo NREQ.
  - Pulse req_ready[g] in the same cycle (combinational on valid & state).
  - Latch op, wdata and g.
  - Set the pointer to (g+1) mod NREQ.
  - Go to SETUP.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven. Next state ACCESS.
- ACCESS:
  - psel=1, penable=1; address/data held stable.
  - On pready=1: capture prdata (reads) and pslverr, go to RESP.
  - Otherwise stay in ACCESS.
- RESP:
  - psel=0.
  - rsp_valid[g]=1 for one cycle; rsp_rdata = captured prdata for reads, 0 for writes; rsp_err = captured error.
  - Next state IDLE.
- Latency with pready=1: grant at cycle T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3. The next grant is possible at T+4.
- Requesters must hold req_valid/op/wdata until req_ready. Deasserting req_valid before grant withdraws the request, no side effect.
- Simultaneous requests: strict round-robin. No requester waits more than NREQ-1 transfers.
- A requester may re-request in the cycle its rsp_valid pulses; it is considered in the next IDLE.
- Only one transfer is outstanding at a time. req_ready is 0 in all states except IDLE.

Optional Feature:
- GPIO_SCHED_TIMEOUT_EN defined:
  - An 8..16-bit counter runs in ACCESS.
  - If pready has stayed 0 for TIMEOUT_CYC cycles, the block drops psel/penable and goes to RESP with rsp_err=1, rsp_rdata=0.
  - The counter clears on entry to SETUP.
- Not defined: ACCESS waits indefinitely for pready; no counter logic is synthesised.

Test Plan:
- Single requester 0, op 5 wdata 0xFF, then op 1 wdata 0xA5 → APB writes to 0x08 then 0x04. Pins read 0xA5. Each rsp_valid[0] arrives 3 cycles after its req_ready, rsp_err=0.
- Requesters 0..3 all valid at once with op 2, masks 0x01/0x02/0x04/0x08 → grants in order 0,1,2,3 with transfers 4 cycles apart. Final output register reads 0x0F.
- op 3 wdata 0x0F after output = 0xFF → pwdata=0xFFFFFFF0 to 0x64; output becomes 0xF0. op 4 wdata 0xFF → output 0x0F.
- Direction 0, external pins driven 0x3C, op 0 → rsp_rdata[7:0]=0x3C. A write op returns rsp_rdata=0.
- pready held low 5 cycles, then pslverr=1 → penable held 6 cycles, rsp_err=1. Assert rst during ACCESS → psel=0 asynchronously, no rsp_valid, the next grant after reset goes to requester 0.
- With GPIO_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, pready tied 0 → abort after 16 ACCESS cycles, rsp_err=1, FSM back in IDLE.
